cmsdk_ahb_trace_buf: RTL

Parametrised AHB-Lite bus trace buffer, successor to the single raw `HADDR_mon` tap on the MCU top level. It passively snoops the system AHB bus and pairs each address phase with its data phase. Completed transfers (address, data, response, attributes) are stored in a DEPTH-entry circular buffer with an address-window filter and a selectable stop-on-full or overwrite mode. Records drain through a valid/ready port to a testbench or debug readout.

---
 rtl/cmsdk_ahb_trace_buf.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/cmsdk_ahb_trace_buf.sv
`timescale 1ns/1ps
// cmsdk_ahb_trace_buf
//
// Passive AHB-Lite bus trace buffer. It snoops the system AHB bus and pairs
// each qualifying address phase with its data phase. Each completed transfer
// is stored in a DEPTH-entry circular buffer. The buffer drains through a
// valid/ready port.
//
// Optional feature macro: ARM_CMSDK_AHB_TRACE_TS_EN
//   When defined, a free-running TSW-bit timestamp is stored with every record
//   and presented on trace_ts. When undefined, the trace_ts port is absent.
//
// Ports:
//   HCLK, HRESET         clock, asynchronous active-high reset
//   enable               capture enable for new address phases
//   clear                synchronous flush of buffer, pending phase, ovf_cnt
//   HADDR..HRDATA        snooped AHB-Lite signals
//   trace_valid/ready    record handshake (pop on valid & ready)
//   trace_addr/data/attr oldest record; attr = {HRESP, HWRITE, HSIZE}
//   trace_ts             oldest record timestamp (macro builds only)
//   count                number of stored records
//   ovf_cnt              dropped or overwritten records, saturating at 255
module cmsdk_ahb_trace_buf #(
  parameter int          AW        = 32,
  parameter int          DW        = 32,
  parameter int          DEPTH     = 16,
  parameter int          WRAP      = 0,
  parameter logic [31:0] FILT_BASE = 32'h0,
  parameter logic [31:0] FILT_MASK = 32'h0,
  parameter int          TSW       = 16
) (
  input  logic                       HCLK,
  input  logic                       HRESET,
  input  logic                       enable,
  input  logic                       clear,
  input  logic [AW-1:0]              HADDR,
  input  logic [1:0]                 HTRANS,
  input  logic                       HWRITE,
  input  logic [2:0]                 HSIZE,
  input  logic                       HREADY,
  input  logic                       HRESP,
  input  logic [DW-1:0]              HWDATA,
  input  logic [DW-1:0]              HRDATA,
  output logic                       trace_valid,
  input  logic                       trace_ready,
  output logic [AW-1:0]              trace_addr,
  output logic [DW-1:0]              trace_data,
  output logic [4:0]                 trace_attr,
`ifdef ARM_CMSDK_AHB_TRACE_TS_EN
  output logic [TSW-1:0]             trace_ts,
`endif
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [7:0]                 ovf_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [AW-1:0] mem_addr_q [DEPTH];
  logic [DW-1:0] mem_data_q [DEPTH];
  logic [4:0]    mem_attr_q [DEPTH];

  logic          pending_q;
  logic [AW-1:0] pa_addr_q;
  logic          pa_write_q;
  logic [2:0]    pa_size_q;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    ovf_q, ovf_d;
  logic          mem_we;

  logic hit, addr_phase, push, pop, full;
  logic unused_htrans0;

  // HTRANS[1] alone separates NONSEQ/SEQ from IDLE/BUSY.
  assign unused_htrans0 = HTRANS[0];

  assign hit        = ((HADDR & AW'(FILT_MASK)) == (AW'(FILT_BASE) & AW'(FILT_MASK)));
  assign addr_phase = HREADY & HTRANS[1] & enable & hit;
  assign push       = HREADY & pending_q;
  assign full       = (count_q == CW'(DEPTH));
  assign pop        = trace_valid & trace_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    mem_we   = 1'b0;
    if (clear) begin
      // Flush wins over any push or pop this cycle; a completing record is lost.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = '0;
    end else begin
      if (push && (pop || !full)) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (!pop) count_d = count_q + 1'b1;
      end else if (push) begin
        ovf_d = sat_inc8(ovf_q);
        if (WRAP != 0) begin
          // Full: write slot equals read slot, so the oldest entry is replaced.
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          rd_ptr_d = rd_ptr_q + 1'b1;
        end
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        if (!push) count_d = count_q - 1'b1;
      end
    end
  end

  // ---- control state ----
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      pending_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      // A new address phase at the completion edge keeps pending set.
      if (clear)           pending_q <= 1'b0;
      else if (addr_phase) pending_q <= 1'b1;
      else if (push)       pending_q <= 1'b0;
    end
  end

  // ---- address-phase attributes and record storage ----
  always_ff @(posedge HCLK) begin
    if (addr_phase) begin
      pa_addr_q  <= HADDR;
      pa_write_q <= HWRITE;
      pa_size_q  <= HSIZE;
    end
    if (mem_we) begin
      mem_addr_q[wr_ptr_q] <= pa_addr_q;
      mem_data_q[wr_ptr_q] <= pa_write_q ? HWDATA : HRDATA;
      mem_attr_q[wr_ptr_q] <= {HRESP, pa_write_q, pa_size_q};
    end
  end

`ifdef ARM_CMSDK_AHB_TRACE_TS_EN
  logic [TSW-1:0] ts_q;
  logic [TSW-1:0] pa_ts_q;
  logic [TSW-1:0] mem_ts_q [DEPTH];

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) ts_q <= '0;
    else        ts_q <= ts_q + 1'b1;
  end

  always_ff @(posedge HCLK) begin
    if (addr_phase) pa_ts_q <= ts_q;
    if (mem_we)     mem_ts_q[wr_ptr_q] <= pa_ts_q;
  end

  assign trace_ts = trace_valid ? mem_ts_q[rd_ptr_q] : '0;
`else
  localparam int unused_tsw = TSW;
`endif

  // Storage is not reset, so fields read as zero whenever the buffer is empty.
  assign trace_valid = (count_q != '0);
  assign trace_addr  = trace_valid ? mem_addr_q[rd_ptr_q] : '0;
  assign trace_data  = trace_valid ? mem_data_q[rd_ptr_q] : '0;
  assign trace_attr  = trace_valid ? mem_attr_q[rd_ptr_q] : '0;
  assign count       = count_q;
  assign ovf_cnt     = ovf_q;

endmodule
